// File: rtl/mem_access_if.sv
// Memory-stage bundle: MEM-stage request, DMEM/IMEM/BIOS ports and UART handshakes.
interface mem_access_if #(
  parameter int DMEM_AW = 14,
  parameter int IMEM_AW = 14,
  parameter int BIOS_AW = 12
);
  logic               mem_valid;
  logic               is_load;
  logic               is_store;
  logic [2:0]         funct3;
  logic [31:0]        addr;
  logic [31:0]        store_data;
  logic [31:0]        pc;
  logic               retire;
  logic               dmem_en;
  logic [3:0]         dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [3:0]         imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        wr_data;
  logic [BIOS_AW-1:0] bios_addr;
  logic [31:0]        dmem_dout;
  logic [31:0]        bios_dout;
  logic [31:0]        load_data;
  logic               misaligned;
  logic [7:0]         uart_tx_data;
  logic               uart_tx_valid;
  logic               uart_tx_ready;
  logic [7:0]         uart_rx_data;
  logic               uart_rx_valid;
  logic               uart_rx_ready;

  modport master (
    output mem_valid, is_load, is_store, funct3, addr, store_data, pc, retire,
           dmem_dout, bios_dout, uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  dmem_en, dmem_we, dmem_addr, imem_we, imem_addr, wr_data, bios_addr,
           load_data, misaligned, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  mem_valid, is_load, is_store, funct3, addr, store_data, pc, retire,
           dmem_dout, bios_dout, uart_tx_ready, uart_rx_data, uart_rx_valid,
    output dmem_en, dmem_we, dmem_addr, imem_we, imem_addr, wr_data, bios_addr,
           load_data, misaligned, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: region decode, byte lanes, aligned/extended load return, MMIO (UART, counters).
//   tx state | meaning
//   TX_IDLE  | no byte pending, a TX store is accepted
//   TX_BUSY  | byte latched, uart_tx_valid high until uart_tx_ready seen on an edge
module mem_access_unit #(
  parameter int DMEM_AW    = 14,
  parameter int IMEM_AW    = 14,
  parameter int BIOS_AW    = 12,
  parameter int CNT_W      = 32,
  parameter bit STRICT_ALN = 1'b1
) (
  input logic         clk_i,
  input logic         rst_i,
  mem_access_if.slave bus_io
);

  localparam logic [31:0] MMIO_STAT = 32'h8000_0000;
  localparam logic [31:0] MMIO_RX   = 32'h8000_0004;
  localparam logic [31:0] MMIO_TX   = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYC  = 32'h8000_0010;
  localparam logic [31:0] MMIO_INS  = 32'h8000_0014;
  localparam logic [31:0] MMIO_CLR  = 32'h8000_0018;

  typedef enum logic [1:0] {SRC_NONE, SRC_DMEM, SRC_BIOS, SRC_MMIO} src_e;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  src_e             src_q, src_d;
  logic [2:0]       f3_q;
  logic [1:0]       off_q, off_d;
  logic [31:0]      mmio_q, mmio_d;
  logic             mis_q;
  tx_state_e        tx_state_q;
  logic [7:0]       tx_data_q;
  logic [CNT_W-1:0] cyc_q, ins_q;

  logic [3:0]  region;
  logic [29:0] wa;
  logic [1:0]  size;
  logic        acc_v, ld, st, ld_ok, st_ok;
  logic        in_dmem, in_imem, in_bios, in_mmio;
  logic        mis_raw, mis;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        tx_busy, tx_wr, cnt_clr;
  logic [31:0] raw, sh, ld_res;
  logic        unused_pc;

  assign region = bus_io.addr[31:28];
  assign wa     = bus_io.addr[31:2];
  assign size   = bus_io.funct3[1:0];
  assign acc_v  = bus_io.mem_valid & ~rst_i;
  assign ld     = acc_v & bus_io.is_load;
  assign st     = acc_v & bus_io.is_store;

  assign in_dmem = (region[3:2] == 2'b00) & region[0];
  assign in_imem = (region[3:1] == 3'b001);
  assign in_bios = (region == 4'b0100);
  assign in_mmio = (region == 4'b1000);

  // size 2'b11 is not a legal RV32 access; it is treated like a word
  assign mis_raw = ((size == 2'b01) & bus_io.addr[0]) | (size[1] & (|bus_io.addr[1:0]));
  assign mis     = STRICT_ALN && mis_raw;
  assign ld_ok   = ld & ~mis;
  assign st_ok   = st & ~mis;

  always_comb begin
    off_d = 2'b00;
    be    = 4'b1111;
    wdata = bus_io.store_data;
    case (size)
      2'b00: begin
        off_d = bus_io.addr[1:0];
        be    = 4'b0001 << off_d;
        wdata = {4{bus_io.store_data[7:0]}};
      end
      2'b01: begin
        off_d = {bus_io.addr[1], 1'b0};
        be    = 4'b0011 << off_d;
        wdata = {2{bus_io.store_data[15:0]}};
      end
      default: begin
        off_d = 2'b00;
        be    = 4'b1111;
        wdata = bus_io.store_data;
      end
    endcase
  end

  assign bus_io.dmem_en   = (ld_ok | st_ok) & in_dmem;
  assign bus_io.dmem_we   = (st_ok & in_dmem) ? be : 4'b0000;
  assign bus_io.imem_we   = (st_ok & in_imem & bus_io.pc[30]) ? be : 4'b0000;
  assign bus_io.dmem_addr = rst_i ? '0 : bus_io.addr[DMEM_AW+1:2];
  assign bus_io.imem_addr = rst_i ? '0 : bus_io.addr[IMEM_AW+1:2];
  assign bus_io.bios_addr = rst_i ? '0 : bus_io.addr[BIOS_AW+1:2];
  assign bus_io.wr_data   = rst_i ? 32'h0 : wdata;

  assign tx_busy = (tx_state_q == TX_BUSY);
  assign tx_wr   = st_ok & (wa == MMIO_TX[31:2]);
  assign cnt_clr = st_ok & (wa == MMIO_CLR[31:2]);

  assign bus_io.uart_rx_ready = ld_ok & (wa == MMIO_RX[31:2]) & bus_io.uart_rx_valid;
  assign bus_io.uart_tx_valid = tx_busy;
  assign bus_io.uart_tx_data  = tx_data_q;
  assign bus_io.misaligned    = mis_q;

  always_comb begin
    mmio_d = 32'h0;
    if (wa == MMIO_STAT[31:2])     mmio_d = {30'h0, bus_io.uart_rx_valid, ~tx_busy};
    else if (wa == MMIO_RX[31:2])  mmio_d = {24'h0, bus_io.uart_rx_data};
    else if (wa == MMIO_CYC[31:2]) mmio_d = 32'(cyc_q);
    else if (wa == MMIO_INS[31:2]) mmio_d = 32'(ins_q);
  end

  always_comb begin
    src_d = SRC_NONE;
    if (ld_ok) begin
      if (in_dmem)      src_d = SRC_DMEM;
      else if (in_bios) src_d = SRC_BIOS;
      else if (in_mmio) src_d = SRC_MMIO;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q      <= SRC_NONE;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      mmio_q     <= 32'h0;
      mis_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_data_q  <= 8'h00;
      cyc_q      <= '0;
      ins_q      <= '0;
    end else begin
      src_q  <= src_d;
      f3_q   <= bus_io.funct3;
      off_q  <= off_d;
      mmio_q <= mmio_d;
      mis_q  <= (ld | st) & mis;
      if (cnt_clr) begin
        cyc_q <= '0;
        ins_q <= '0;
      end else begin
        cyc_q <= cyc_q + CNT_W'(1);
        if (bus_io.retire) ins_q <= ins_q + CNT_W'(1);
      end
      // a TX store arriving while a byte is pending is dropped
      if (!tx_busy) begin
        if (tx_wr) begin
          tx_data_q  <= bus_io.store_data[7:0];
          tx_state_q <= TX_BUSY;
        end
      end else if (bus_io.uart_tx_ready) begin
        tx_state_q <= TX_IDLE;
      end
    end
  end

  always_comb begin
    case (src_q)
      SRC_DMEM: raw = bus_io.dmem_dout;
      SRC_BIOS: raw = bus_io.bios_dout;
      SRC_MMIO: raw = mmio_q;
      default:  raw = 32'h0;
    endcase
    sh = raw >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_res = {24'h0, sh[7:0]};
      3'b101:  ld_res = {16'h0, sh[15:0]};
      default: ld_res = sh;
    endcase
  end

  assign bus_io.load_data = ld_res;
  assign unused_pc = ^{bus_io.pc[31], bus_io.pc[29:0]};

endmodule
